// File: rtl/satd_pkg.sv
// Shared SATD datapath constants, row word type and packer state encoding.
package satd_pkg;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned ROW_PIX = 8;
    localparam int unsigned ROW_W   = PIX_W * ROW_PIX;
    localparam int unsigned CNT_W   = $clog2(ROW_PIX);
    localparam int unsigned IDX_W   = 3;

    typedef logic [ROW_W-1:0] row_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [IDX_W-1:0] row_idx_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/satd_row_packer_if.sv
// Pixel-pair input channel and packed-row output channel of the row packer.
interface satd_row_packer_if;
    import satd_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_org;
    logic [PIX_W-1:0] in_cur;
    logic             in_last;
    row_t             ORG;
    row_t             CUR;
    logic             out_valid;
    logic             out_ready;
    row_idx_t         out_row;
    logic             out_last;

    modport master (
        output in_valid, in_org, in_cur, in_last, out_ready,
        input  in_ready, ORG, CUR, out_valid, out_row, out_last
    );

    modport slave (
        input  in_valid, in_org, in_cur, in_last, out_ready,
        output in_ready, ORG, CUR, out_valid, out_row, out_last
    );
endinterface

// File: rtl/satd_row_slot.sv
// Output holding register for one packed ORG/CUR row with its row index and last tag.
module satd_row_slot
    import satd_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  row_t     load_org,
    input  row_t     load_cur,
    input  logic     load_last,
    input  logic     ready,
    output row_t     org,
    output row_t     cur,
    output logic     occupied,
    output logic     free,
    output row_idx_t row_idx,
    output logic     last
);
    row_idx_t next_idx;

    assign free = !occupied || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            org      <= '0;
            cur      <= '0;
            occupied <= 1'b0;
            row_idx  <= '0;
            last     <= 1'b0;
            next_idx <= '0;
        end else if (load) begin
            org      <= load_org;
            cur      <= load_cur;
            occupied <= 1'b1;
            row_idx  <= next_idx;
            last     <= load_last;
            // Row numbering restarts with the block after a closing row.
            next_idx <= load_last ? '0 : next_idx + row_idx_t'(1);
        end else if (ready) begin
            occupied <= 1'b0;
        end
    end
endmodule

// File: rtl/satd_row_packer.sv
// Packs ORG/CUR pixel pairs into 64-bit row words for the SATD core.
module satd_row_packer
    import satd_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    satd_row_packer_if.slave    bus
);
    state_t state, state_nxt;
    cnt_t   cnt;
    row_t   asm_org, asm_cur;
    row_t   wr_org, wr_cur;
    row_t   load_org, load_cur;
    logic   hold_last;
    logic   accept, closing;
    logic   slot_free, slot_load, slot_occupied, load_last;
    logic   in_ready_c;

    assign accept  = bus.in_valid && in_ready_c;
    assign closing = accept && ((cnt == cnt_t'(ROW_PIX - 1)) || bus.in_last);
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = slot_occupied;

    // Lanes above cnt are still zero from the last clear, so a closing write is already padded.
    always_comb begin
        wr_org = asm_org;
        wr_cur = asm_cur;
        for (int unsigned k = 0; k < ROW_PIX; k++) begin
            if (cnt == cnt_t'(k)) begin
                wr_org[k*PIX_W +: PIX_W] = bus.in_org;
                wr_cur[k*PIX_W +: PIX_W] = bus.in_cur;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (closing && !slot_free) state_nxt = HOLD;
            HOLD:    if (slot_free)             state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        in_ready_c = (state == FILL);
        slot_load  = 1'b0;
        load_org   = wr_org;
        load_cur   = wr_cur;
        load_last  = bus.in_last;
        if (state == HOLD) begin
            slot_load = slot_free;
            load_org  = asm_org;
            load_cur  = asm_cur;
            load_last = hold_last;
        end else begin
            slot_load = closing && slot_free;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            asm_org   <= '0;
            asm_cur   <= '0;
            hold_last <= 1'b0;
        end else if (state == HOLD) begin
            if (slot_free) begin
                asm_org   <= '0;
                asm_cur   <= '0;
                hold_last <= 1'b0;
            end
        end else if (accept) begin
            if (closing) begin
                cnt <= '0;
                if (slot_free) begin
                    asm_org <= '0;
                    asm_cur <= '0;
                end else begin
                    asm_org   <= wr_org;
                    asm_cur   <= wr_cur;
                    hold_last <= bus.in_last;
                end
            end else begin
                asm_org <= wr_org;
                asm_cur <= wr_cur;
                cnt     <= cnt + cnt_t'(1);
            end
        end
    end

    satd_row_slot u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (slot_load),
        .load_org  (load_org),
        .load_cur  (load_cur),
        .load_last (load_last),
        .ready     (bus.out_ready),
        .org       (bus.ORG),
        .cur       (bus.CUR),
        .occupied  (slot_occupied),
        .free      (slot_free),
        .row_idx   (bus.out_row),
        .last      (bus.out_last)
    );
endmodule

// File: tb/tb_satd_row_packer.sv
// Scoreboard bench for satd_row_packer: expected rows queued at accept, checked at transfer.
module tb_satd_row_packer;
    logic clk;
    logic rst;

    satd_row_packer_if bus ();

    satd_row_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] org;
        logic [63:0] cur;
        logic [2:0]  row;
        logic        last;
    } row_exp_t;

    row_exp_t    sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          stalls = 0;
    logic [63:0] m_org, m_cur;
    int          m_cnt = 0;
    int          m_row = 0;
    bit          rand_on = 0;

    bit          have_prev = 0;
    logic [63:0] p_org, p_cur;
    logic [2:0]  p_row;
    logic        p_last;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        m_org = '0;
        m_cur = '0;
        m_cnt = 0;
        m_row = 0;
    endtask

    task automatic model_accept(input logic [7:0] o, input logic [7:0] c, input logic l);
        row_exp_t e;
        m_org[m_cnt*8 +: 8] = o;
        m_cur[m_cnt*8 +: 8] = c;
        if (l || m_cnt == 7) begin
            e.org  = m_org;
            e.cur  = m_cur;
            e.row  = 3'(m_row);
            e.last = l;
            sb.push_back(e);
            m_row = l ? 0 : (m_row + 1) % 8;
            m_org = '0;
            m_cur = '0;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one pair; returns one time unit after the accepting edge.
    task automatic send(input logic [7:0] o, input logic [7:0] c, input logic l);
        int unsigned waited = 0;
        bit done = 0;
        bus.in_valid = 1'b1;
        bus.in_org   = o;
        bus.in_cur   = c;
        bus.in_last  = l;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                model_accept(o, c, l);
                done = 1;
            end else begin
                waited++;
                stalls++;
                if (waited > 200) begin
                    check("send_timeout", 64'(waited), 64'(0));
                    done = 1;
                end
            end
        end
        step();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, "_org"},   bus.ORG,            64'(0));
        check({tag, "_cur"},   bus.CUR,            64'(0));
        check({tag, "_row"},   64'(bus.out_row),   64'(0));
        check({tag, "_last"},  64'(bus.out_last),  64'(0));
    endtask

    task automatic do_reset(input string tag);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_cleared(tag);
        model_clear();
        step();
        rst = 1'b0;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
        step();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            have_prev = 0;
        end else begin
            if (have_prev) begin
                check("hold_valid", 64'(bus.out_valid), 64'(1));
                check("hold_org",   bus.ORG,            p_org);
                check("hold_cur",   bus.CUR,            p_cur);
                check("hold_row",   64'(bus.out_row),   64'(p_row));
                check("hold_last",  64'(bus.out_last),  64'(p_last));
            end
            have_prev = bus.out_valid && !bus.out_ready;
            p_org  = bus.ORG;
            p_cur  = bus.CUR;
            p_row  = bus.out_row;
            p_last = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_row", 64'(bus.out_valid), 64'(0));
                end else begin
                    row_exp_t e;
                    e = sb.pop_front();
                    check("row_org",  bus.ORG,           e.org);
                    check("row_cur",  bus.CUR,           e.cur);
                    check("row_idx",  64'(bus.out_row),  64'(e.row));
                    check("row_last", 64'(bus.out_last), 64'(e.last));
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_on) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int acc;
        int waited;
        clk = 1'b0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_org    = '0;
        bus.in_cur    = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        model_clear();
        #2;
        check_cleared("por");
        step();
        rst = 1'b0;
        @(negedge clk);
        check("por_in_ready", 64'(bus.in_ready), 64'(1));
        step();

        // Full row with a free slot: visible the cycle after the closing accept.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(8'(i + 1), 8'(8'h11 + i), 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("full_valid", 64'(bus.out_valid), 64'(1));
        check("full_org",   bus.ORG, 64'h0807060504030201);
        check("full_cur",   bus.CUR, 64'h1817161514131211);
        check("full_row",   64'(bus.out_row), 64'(0));
        step();
        step();

        // Backpressure: slot plus assembly hold 16 pairs; the 17th waits.
        do_reset("rst_bp");
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 17; i++) begin
            bus.in_valid = 1'b1;
            bus.in_org   = 8'(8'h21 + i);
            bus.in_cur   = 8'(8'h41 + i);
            bus.in_last  = 1'b0;
            @(negedge clk);
            if (bus.in_ready) begin
                model_accept(bus.in_org, bus.in_cur, 1'b0);
                acc++;
            end
            if (i == 16) check("bp_in_ready", 64'(bus.in_ready), 64'(0));
            step();
        end
        bus.in_valid = 1'b0;
        check("bp_accepts", 64'(acc), 64'(16));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp_row1_valid", 64'(bus.out_valid), 64'(1));
        check("bp_row1_idx",   64'(bus.out_row),   64'(1));
        check("bp_in_ready_back", 64'(bus.in_ready), 64'(1));
        step();
        bus.out_ready = 1'b1;
        step();
        step();

        // Early close on the third pair pads upper lanes and restarts row numbering.
        send(8'h01, 8'h31, 1'b0);
        send(8'h02, 8'h32, 1'b0);
        send(8'h03, 8'h33, 1'b1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("early_org",  bus.ORG, 64'h0000000000030201);
        check("early_last", 64'(bus.out_last), 64'(1));
        step();
        for (int i = 0; i < 8; i++) send(8'(8'h61 + i), 8'(8'h71 + i), 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("early_next_row", 64'(bus.out_row), 64'(0));
        step();

        // Streaming: nine rows back-to-back, row index wraps after 7.
        do_reset("rst_stream");
        bus.out_ready = 1'b1;
        stalls = 0;
        for (int i = 0; i < 72; i++) send(8'(i), 8'(8'hff - i), 1'b0);
        bus.in_valid = 1'b0;
        check("stream_stalls", 64'(stalls), 64'(0));
        @(negedge clk);
        check("stream_wrap_row", 64'(bus.out_row), 64'(0));
        step();

        // Reset mid-row with a held row on output.
        do_reset("rst_pre6");
        bus.out_ready = 1'b0;
        for (int i = 0; i < 13; i++) send(8'(8'h81 + i), 8'(8'h91 + i), 1'b0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_cleared("rst_mid");
        model_clear();
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(8'(8'h51 + i), 8'(8'ha1 + i), 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("mid_org", bus.ORG, 64'h5857565554535251);
        check("mid_row", 64'(bus.out_row), 64'(0));
        step();

        // Random gaps, random in_last and random consumer stalls.
        rand_on = 1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                step();
            end
            send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 7) == 0));
        end
        bus.in_valid = 1'b0;
        rand_on = 0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        // Trailing partial row is flushed with an in_last pair.
        send(8'h5a, 8'ha5, 1'b1);
        bus.in_valid = 1'b0;
        waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            step();
            waited++;
        end
        check("drain_pending", 64'(sb.size()), 64'(0));
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
